// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: field widths, opcodes and default-width beat structs.
package tl_pkg;

   localparam int unsigned TL_OP_W      = 3;
   localparam int unsigned TL_A_PARAM_W = 3;
   localparam int unsigned TL_D_PARAM_W = 2;
   localparam int unsigned TL_ADDR_W    = 32;
   localparam int unsigned TL_DATA_W    = 32;
   localparam int unsigned TL_SRC_W     = 3;
   localparam int unsigned TL_SINK_W    = 1;
   localparam int unsigned TL_SIZE_W    = 3;

   localparam logic [TL_OP_W-1:0] TL_A_GET              = 3'd4;
   localparam logic [TL_OP_W-1:0] TL_A_PUT_FULL_DATA    = 3'd0;
   localparam logic [TL_OP_W-1:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [TL_OP_W-1:0] TL_D_ACCESS_ACK       = 3'd0;
   localparam logic [TL_OP_W-1:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

   typedef struct packed {
      logic [TL_OP_W-1:0]      opcode;
      logic [TL_A_PARAM_W-1:0] param;
      logic [TL_SIZE_W-1:0]    size;
      logic [TL_SRC_W-1:0]     source;
      logic [TL_ADDR_W-1:0]    address;
      logic [TL_DATA_W/8-1:0]  mask;
      logic [TL_DATA_W-1:0]    data;
      logic                    corrupt;
   } tl_a_beat_t;

   typedef struct packed {
      logic [TL_OP_W-1:0]      opcode;
      logic [TL_D_PARAM_W-1:0] param;
      logic [TL_SIZE_W-1:0]    size;
      logic [TL_SRC_W-1:0]     source;
      logic [TL_SINK_W-1:0]    sink;
      logic                    denied;
      logic [TL_DATA_W-1:0]    data;
      logic                    corrupt;
   } tl_d_beat_t;

endpackage

// File: rtl/tl_queue.sv
// Generic valid/ready circular-buffer queue with optional flow-through and pipe modes.
// DEPTH=0 collapses to a plain wire.
module tl_queue #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   parameter bit          FLOW  = 1'b0,
   parameter bit          PIPE  = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [4:0]       o_count
);

   if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused    = clock ^ reset_n;
      assign o_in_ready  = i_out_ready;
      assign o_out_valid = i_in_valid;
      assign o_out_data  = i_in_data;
      assign o_count     = '0;
   end else begin : g_queue
      localparam int unsigned     PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
      localparam logic [4:0]       FULL = 5'(DEPTH);

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0] r_wptr, r_rptr;
      logic [4:0]       r_count;
      logic             w_empty, w_enq, w_deq, w_write, w_read;

      assign w_empty     = (r_count == 5'd0);
      assign o_in_ready  = (r_count != FULL) | (PIPE & i_out_ready);
      assign o_out_valid = !w_empty | (FLOW & i_in_valid);
      assign w_enq       = i_in_valid & o_in_ready;
      assign w_deq       = o_out_valid & i_out_ready;
      // A bypassed beat (flow-through while empty) never touches storage.
      assign w_write     = w_enq & !(FLOW & w_empty & w_deq);
      assign w_read      = w_deq & !w_empty;
      assign o_out_data  = (FLOW && w_empty) ? i_in_data : r_mem[r_rptr];
      assign o_count     = r_count;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         end else begin
            if (w_write) begin
               r_mem[r_wptr] <= i_in_data;
               r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_read) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + 5'(w_write) - 5'(w_read);
         end
      end

      a_out_stable: assert property (@(posedge clock) disable iff (!reset_n)
         (o_out_valid && !i_out_ready) |=> $stable(o_out_data));
      a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
         r_count <= FULL);
   end

endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink-UL A/D channel buffer: one independent tl_queue per channel; this level only
// packs and unpacks beats.
module tl_channel_buffer
   import tl_pkg::*;
#(
   parameter int unsigned ADDR_W  = TL_ADDR_W,
   parameter int unsigned DATA_W  = TL_DATA_W,
   parameter int unsigned SRC_W   = TL_SRC_W,
   parameter int unsigned SINK_W  = TL_SINK_W,
   parameter int unsigned SIZE_W  = TL_SIZE_W,
   parameter int unsigned A_DEPTH = 2,
   parameter int unsigned D_DEPTH = 2,
   parameter bit          A_FLOW  = 1'b0,
   parameter bit          D_FLOW  = 1'b0,
   parameter bit          A_PIPE  = 1'b0,
   parameter bit          D_PIPE  = 1'b0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    i_a_valid,
   output logic                    i_a_ready,
   input  logic [TL_OP_W-1:0]      i_a_opcode,
   input  logic [TL_A_PARAM_W-1:0] i_a_param,
   input  logic [SIZE_W-1:0]       i_a_size,
   input  logic [SRC_W-1:0]        i_a_source,
   input  logic [ADDR_W-1:0]       i_a_address,
   input  logic [DATA_W/8-1:0]     i_a_mask,
   input  logic [DATA_W-1:0]       i_a_data,
   input  logic                    i_a_corrupt,
   output logic                    o_a_valid,
   input  logic                    o_a_ready,
   output logic [TL_OP_W-1:0]      o_a_opcode,
   output logic [TL_A_PARAM_W-1:0] o_a_param,
   output logic [SIZE_W-1:0]       o_a_size,
   output logic [SRC_W-1:0]        o_a_source,
   output logic [ADDR_W-1:0]       o_a_address,
   output logic [DATA_W/8-1:0]     o_a_mask,
   output logic [DATA_W-1:0]       o_a_data,
   output logic                    o_a_corrupt,
   input  logic                    i_d_valid,
   output logic                    i_d_ready,
   input  logic [TL_OP_W-1:0]      i_d_opcode,
   input  logic [TL_D_PARAM_W-1:0] i_d_param,
   input  logic [SIZE_W-1:0]       i_d_size,
   input  logic [SRC_W-1:0]        i_d_source,
   input  logic [SINK_W-1:0]       i_d_sink,
   input  logic                    i_d_denied,
   input  logic [DATA_W-1:0]       i_d_data,
   input  logic                    i_d_corrupt,
   output logic                    o_d_valid,
   input  logic                    o_d_ready,
   output logic [TL_OP_W-1:0]      o_d_opcode,
   output logic [TL_D_PARAM_W-1:0] o_d_param,
   output logic [SIZE_W-1:0]       o_d_size,
   output logic [SRC_W-1:0]        o_d_source,
   output logic [SINK_W-1:0]       o_d_sink,
   output logic                    o_d_denied,
   output logic [DATA_W-1:0]       o_d_data,
   output logic                    o_d_corrupt,
   output logic [4:0]              a_count,
   output logic [4:0]              d_count
);

   typedef struct packed {
      logic [TL_OP_W-1:0]      opcode;
      logic [TL_A_PARAM_W-1:0] param;
      logic [SIZE_W-1:0]       size;
      logic [SRC_W-1:0]        source;
      logic [ADDR_W-1:0]       address;
      logic [DATA_W/8-1:0]     mask;
      logic [DATA_W-1:0]       data;
      logic                    corrupt;
   } a_beat_t;

   typedef struct packed {
      logic [TL_OP_W-1:0]      opcode;
      logic [TL_D_PARAM_W-1:0] param;
      logic [SIZE_W-1:0]       size;
      logic [SRC_W-1:0]        source;
      logic [SINK_W-1:0]       sink;
      logic                    denied;
      logic [DATA_W-1:0]       data;
      logic                    corrupt;
   } d_beat_t;

   a_beat_t w_a_in, w_a_out;
   d_beat_t w_d_in, w_d_out;

   assign w_a_in = '{opcode: i_a_opcode, param: i_a_param, size: i_a_size,
                     source: i_a_source, address: i_a_address, mask: i_a_mask,
                     data: i_a_data, corrupt: i_a_corrupt};
   assign w_d_in = '{opcode: i_d_opcode, param: i_d_param, size: i_d_size,
                     source: i_d_source, sink: i_d_sink, denied: i_d_denied,
                     data: i_d_data, corrupt: i_d_corrupt};

   tl_queue #(
      .WIDTH ($bits(a_beat_t)),
      .DEPTH (A_DEPTH),
      .FLOW  (A_FLOW),
      .PIPE  (A_PIPE)
   ) u_a_queue (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_in_valid  (i_a_valid),
      .o_in_ready  (i_a_ready),
      .i_in_data   (w_a_in),
      .o_out_valid (o_a_valid),
      .i_out_ready (o_a_ready),
      .o_out_data  (w_a_out),
      .o_count     (a_count)
   );

   tl_queue #(
      .WIDTH ($bits(d_beat_t)),
      .DEPTH (D_DEPTH),
      .FLOW  (D_FLOW),
      .PIPE  (D_PIPE)
   ) u_d_queue (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_in_valid  (i_d_valid),
      .o_in_ready  (i_d_ready),
      .i_in_data   (w_d_in),
      .o_out_valid (o_d_valid),
      .i_out_ready (o_d_ready),
      .o_out_data  (w_d_out),
      .o_count     (d_count)
   );

   assign o_a_opcode  = w_a_out.opcode;
   assign o_a_param   = w_a_out.param;
   assign o_a_size    = w_a_out.size;
   assign o_a_source  = w_a_out.source;
   assign o_a_address = w_a_out.address;
   assign o_a_mask    = w_a_out.mask;
   assign o_a_data    = w_a_out.data;
   assign o_a_corrupt = w_a_out.corrupt;

   assign o_d_opcode  = w_d_out.opcode;
   assign o_d_param   = w_d_out.param;
   assign o_d_size    = w_d_out.size;
   assign o_d_source  = w_d_out.source;
   assign o_d_sink    = w_d_out.sink;
   assign o_d_denied  = w_d_out.denied;
   assign o_d_data    = w_d_out.data;
   assign o_d_corrupt = w_d_out.corrupt;

endmodule
